// File: rtl/ft232h_tx_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// ft232h_tx_scheduler_pkg
// Shared defaults and types for the FT232H FT245-synchronous TX scheduler.
//   FT232H_TX_NUM_SOURCES    default number of AXI-stream producers
//   FT232H_FLUSH_IDLE_CYCLES default idle gap before a send-immediate pulse
//   ft232h_tx_state_t        scheduler FSM state (also exported for debug)
// ---------------------------------------------------------------------------
package ft232h_tx_scheduler_pkg;

   localparam int FT232H_TX_NUM_SOURCES    = 4;
   localparam int FT232H_FLUSH_IDLE_CYCLES = 64;

   typedef enum logic [0:0] {
      TX_IDLE = 1'b0,
      TX_XFER = 1'b1
   } ft232h_tx_state_t;

endpackage

// File: rtl/ft232h_tx_scheduler_if.sv
// ---------------------------------------------------------------------------
// ft232h_tx_scheduler_if
// Bundle of NUM_SOURCES AXI-stream byte producers feeding the scheduler.
//   s_axis_tdata   byte of source i at [8i+7:8i]
//   s_axis_tvalid  per-source valid
//   s_axis_tlast   per-source end of packet
//   s_axis_tready  per-source ready (at most one bit high)
// Handshake: a beat of source i transfers on a rising clk edge where
// s_axis_tvalid[i] && s_axis_tready[i]; once raised, tvalid and the beat
// (tdata/tlast) stay stable until that transfer; tready may change freely.
// master = producer side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface ft232h_tx_scheduler_if #(
   parameter int NUM_SOURCES = 4
);
   logic [NUM_SOURCES*8-1:0] s_axis_tdata;
   logic [NUM_SOURCES-1:0]   s_axis_tvalid;
   logic [NUM_SOURCES-1:0]   s_axis_tlast;
   logic [NUM_SOURCES-1:0]   s_axis_tready;

   modport master (
      output s_axis_tdata,
      output s_axis_tvalid,
      output s_axis_tlast,
      input  s_axis_tready
   );

   modport slave (
      input  s_axis_tdata,
      input  s_axis_tvalid,
      input  s_axis_tlast,
      output s_axis_tready
   );
endinterface

// File: rtl/ft232h_tx_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first requesting index strictly
// after last_grant, wrapping modulo N. If only last_grant requests, it is
// picked again (search covers N positions, ending on last_grant itself).
//   req         in  N      request vector
//   last_grant  in  GW     previously granted index
//   next_grant  out GW     index to grant (last_grant when nothing requests)
//   any_req     out 1      at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int GW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [GW-1:0] last_grant,
   output logic [GW-1:0] next_grant,
   output logic          any_req
);

   logic found;
   int   cand;

   assign any_req = |req;

   always_comb begin
      next_grant = last_grant;
      found      = 1'b0;
      cand       = 0;
      for (int i = 1; i <= N; i++) begin
         cand = int'(last_grant) + i;
         if (cand >= N) cand = cand - N;
         if (!found && req[cand[GW-1:0]]) begin
            next_grant = cand[GW-1:0];
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ft232h_tx_scheduler.sv
// ---------------------------------------------------------------------------
// ft232h_tx_scheduler
// Packet-granular round-robin scheduler sharing the FT232H FT245-synchronous
// write port among NUM_SOURCES AXI-stream producers. Runs on the FT232H
// CLKOUT. Pulses siwu_n after an idle gap to push out a partial USB packet.
//   clk, rst_n   FT232H clock; async-assert active-low reset (deassert synced)
//   axis         slave side of the AXI-stream bundle
//   txe_n        FT232H TX FIFO has space when low
//   wr_n, data   write strobe and byte; taken on rising clk when both low
//   rd_n, oe_n   held inactive (1)
//   siwu_n       one-clk low send-immediate pulse
//   grant        current or last granted source
//   busy         packet in flight (from grant until its last byte is written)
//   state        FSM state, exported for debug
// ---------------------------------------------------------------------------
module ft232h_tx_scheduler
   import ft232h_tx_scheduler_pkg::*;
#(
   parameter  int NUM_SOURCES       = FT232H_TX_NUM_SOURCES,
   parameter  int FLUSH_IDLE_CYCLES = FT232H_FLUSH_IDLE_CYCLES,
   localparam int GW                = $clog2(NUM_SOURCES)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   ft232h_tx_scheduler_if.slave    axis,
   input  logic                    txe_n,
   output logic                    wr_n,
   output logic [7:0]              data,
   output logic                    rd_n,
   output logic                    oe_n,
   output logic                    siwu_n,
   output logic [GW-1:0]           grant,
   output logic                    busy,
   output ft232h_tx_state_t        state
);

   localparam int CW     = (FLUSH_IDLE_CYCLES > 1) ? $clog2(FLUSH_IDLE_CYCLES) : 1;
   localparam int LAST_I = (FLUSH_IDLE_CYCLES > 0) ? FLUSH_IDLE_CYCLES - 1 : 0;
   localparam logic [CW-1:0] CNT_LAST = CW'(LAST_I);
   localparam bit FLUSH_EN = (FLUSH_IDLE_CYCLES > 0);

   // Reset: asserts asynchronously, releases two clocks later.
   logic [1:0] rst_sync;
   logic       rst_int_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_int_n = rst_sync[1];

   logic          out_valid;
   logic          stage_free;
   logic          written;
   logic          accept;
   logic [7:0]    sel_data;
   logic          sel_last;
   logic [GW-1:0] next_grant;
   logic          any_req;
   logic [CW-1:0] idle_cnt;
   logic          dirty;

   assign rd_n = 1'b1;
   assign oe_n = 1'b1;
   assign wr_n = ~out_valid;

   // While a byte is presented and txe_n is high, the stage holds it untouched.
   assign stage_free = !out_valid || !txe_n;
   assign written    = out_valid && !txe_n;
   assign sel_data   = axis.s_axis_tdata[{grant, 3'b000} +: 8];
   assign sel_last   = axis.s_axis_tlast[grant];
   assign accept     = (state == TX_XFER) && stage_free && axis.s_axis_tvalid[grant];

   // Only combinational path through the block: txe_n -> tready.
   always_comb begin
      axis.s_axis_tready = '0;
      if ((state == TX_XFER) && stage_free) axis.s_axis_tready[grant] = 1'b1;
   end

   rr_arbiter #(.N(NUM_SOURCES)) u_rr_arbiter (
      .req        (axis.s_axis_tvalid),
      .last_grant (grant),
      .next_grant (next_grant),
      .any_req    (any_req)
   );

   // Scheduler FSM. The grant cycle spends one clock in IDLE, so no beat is
   // taken in it; busy stays high in IDLE until the final byte leaves.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state <= TX_IDLE;
         grant <= GW'(NUM_SOURCES - 1);
         busy  <= 1'b0;
      end else begin
         case (state)
            TX_IDLE: begin
               if (any_req) begin
                  grant <= next_grant;
                  state <= TX_XFER;
                  busy  <= 1'b1;
               end else begin
                  busy  <= out_valid && txe_n;
               end
            end
            TX_XFER: begin
               if (accept && sel_last) state <= TX_IDLE;
            end
            default: state <= TX_IDLE;
         endcase
      end
   end

   // Output stage {data, out_valid}.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         out_valid <= 1'b0;
         data      <= 8'h00;
      end else if (accept) begin
         out_valid <= 1'b1;
         data      <= sel_data;
      end else if (written) begin
         out_valid <= 1'b0;
      end
   end

   // Flush timer: counts idle clocks after the last written byte. The pulse
   // fires only when the stage stays empty, so siwu_n and wr_n never overlap;
   // a beat loaded on that same edge cancels it.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         idle_cnt <= '0;
         dirty    <= 1'b0;
         siwu_n   <= 1'b1;
      end else begin
         siwu_n <= 1'b1;
         if (written) dirty <= 1'b1;
         if (out_valid) begin
            idle_cnt <= '0;
         end else if (dirty && FLUSH_EN) begin
            if (idle_cnt == CNT_LAST) begin
               if (!accept) begin
                  siwu_n   <= 1'b0;
                  dirty    <= 1'b0;
                  idle_cnt <= '0;
               end
            end else begin
               idle_cnt <= idle_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ft232h_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ft232h_tx_scheduler
// Directed bench for ft232h_tx_scheduler (4 sources, flush gap of 8 clocks).
// Inputs change on the falling edge; outputs are sampled there too. Per-source
// queues feed the AXI-stream side, an FT232H sink consumes written bytes and
// checks them against the expected queue exp_q.
// ---------------------------------------------------------------------------
module tb_ft232h_tx_scheduler;
   import ft232h_tx_scheduler_pkg::*;

   localparam int NS    = 4;
   localparam int FLUSH = 8;

   // ---------------- clock / reset / DUT ----------------
   logic             clk = 1'b0;
   logic             rst_n;
   logic             txe_n;
   logic             wr_n;
   logic [7:0]       data;
   logic             rd_n;
   logic             oe_n;
   logic             siwu_n;
   logic [1:0]       grant;
   logic             busy;
   ft232h_tx_state_t state;

   always #5 clk = ~clk;

   ft232h_tx_scheduler_if #(.NUM_SOURCES(NS)) axis ();

   ft232h_tx_scheduler #(
      .NUM_SOURCES       (NS),
      .FLUSH_IDLE_CYCLES (FLUSH)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .axis   (axis),
      .txe_n  (txe_n),
      .wr_n   (wr_n),
      .data   (data),
      .rd_n   (rd_n),
      .oe_n   (oe_n),
      .siwu_n (siwu_n),
      .grant  (grant),
      .busy   (busy),
      .state  (state)
   );

   // ---------------- scoreboard state ----------------
   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         wr_cnt = 0;
   int         last_wr_cyc = 0;
   int         siwu_cnt = 0;
   int         siwu_cyc = 0;
   int         pkt_cnt [NS];
   bit         rnd_txe = 1'b0;
   logic [7:0] exp_q [$];
   logic [8:0] src_q [NS][$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive();
      logic [8:0] h;
      for (int i = 0; i < NS; i++) begin
         if (src_q[i].size() != 0) begin
            h = src_q[i][0];
            axis.s_axis_tvalid[i]        = 1'b1;
            axis.s_axis_tdata[i*8 +: 8] = h[7:0];
            axis.s_axis_tlast[i]         = h[8];
         end else begin
            axis.s_axis_tvalid[i]        = 1'b0;
            axis.s_axis_tdata[i*8 +: 8] = 8'h00;
            axis.s_axis_tlast[i]         = 1'b0;
         end
      end
      if (rnd_txe) txe_n = ($urandom_range(0, 3) == 0);
      #1;
   endtask

   // One clock: sample handshakes, let the edge pass, update model, redrive.
   task automatic tick();
      logic [NS-1:0] acc;
      logic [NS-1:0] lst;
      logic          wr;
      logic [7:0]    b;
      logic [1:0]    g;
      acc = axis.s_axis_tvalid & axis.s_axis_tready;
      lst = axis.s_axis_tlast;
      wr  = !wr_n && !txe_n;
      b   = data;
      g   = grant;
      check("tready_onehot0", 32'($onehot0(axis.s_axis_tready)), 32'd1);
      check("siwu_during_wr", 32'(!siwu_n && !wr_n), 32'd0);
      if (acc != '0) check("accept_from_grant", 32'(acc), 32'(1) << g);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
         if (acc[i]) begin
            if (lst[i]) pkt_cnt[i]++;
            void'(src_q[i].pop_front());
         end
      end
      if (wr) begin
         wr_cnt++;
         last_wr_cyc = cyc;
         if (exp_q.size() == 0) check("write_byte", 32'(b), 32'h100);
         else                   check("write_byte", 32'(b), 32'(exp_q.pop_front()));
      end
      if (!siwu_n) begin
         siwu_cnt++;
         siwu_cyc = cyc;
      end
      drive();
   endtask

   task automatic run_until(input int target, input int budget, input string tag);
      int k;
      k = 0;
      while (wr_cnt < target && k < budget) begin
         tick();
         k++;
      end
      check(tag, 32'(wr_cnt), 32'(target));
   endtask

   task automatic push_src(input int s, input logic [7:0] b, input logic last);
      src_q[s].push_back({last, b});
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: observed no completion, expected summary before 500000 ns");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int wr0, k, len, s, kk, total;
      for (int i = 0; i < NS; i++) pkt_cnt[i] = 0;
      rst_n = 1'b0;
      txe_n = 1'b1;
      axis.s_axis_tvalid = '0;
      axis.s_axis_tlast  = '0;
      axis.s_axis_tdata  = '0;
      @(negedge clk);
      drive();

      // Reset values
      check("rst_wr_n",   32'(wr_n), 32'd1);
      check("rst_data",   32'(data), 32'h00);
      check("rst_siwu_n", 32'(siwu_n), 32'd1);
      check("rst_rd_n",   32'(rd_n), 32'd1);
      check("rst_oe_n",   32'(oe_n), 32'd1);
      check("rst_tready", 32'(axis.s_axis_tready), 32'd0);
      check("rst_grant",  32'(grant), 32'd3);
      check("rst_busy",   32'(busy), 32'd0);
      check("rst_state",  32'(state), 32'(TX_IDLE));
      tick();
      tick();
      rst_n = 1'b1;
      repeat (4) tick();
      check("post_rst_grant", 32'(grant), 32'd3);

      // 1: source 0, 01..04, txe_n low -> four consecutive writes
      txe_n = 1'b0;
      for (int j = 1; j <= 4; j++) begin
         push_src(0, 8'(j), j == 4);
         exp_q.push_back(8'(j));
      end
      drive();
      check("t1_no_accept_idle", 32'(axis.s_axis_tready), 32'd0);
      tick();
      check("t1_grant",  32'(grant), 32'd0);
      check("t1_busy",   32'(busy), 32'd1);
      check("t1_state",  32'(state), 32'(TX_XFER));
      check("t1_wr_n_0", 32'(wr_n), 32'd1);
      check("t1_tready", 32'(axis.s_axis_tready), 32'b0001);
      for (int j = 1; j <= 4; j++) begin
         tick();
         check("t1_wr_n", 32'(wr_n), 32'd0);
         check("t1_data", 32'(data), 32'(j));
      end
      tick();
      check("t1_wr_n_end", 32'(wr_n), 32'd1);
      check("t1_busy_end", 32'(busy), 32'd0);
      check("t1_wr_cnt",   32'(wr_cnt), 32'd4);

      // 2: sources 1 and 3 together -> 1 first, then 3, not interleaved
      push_src(1, 8'h11, 1'b0); push_src(1, 8'h12, 1'b0); push_src(1, 8'h13, 1'b1);
      push_src(3, 8'h31, 1'b0); push_src(3, 8'h32, 1'b0); push_src(3, 8'h33, 1'b1);
      exp_q.push_back(8'h11); exp_q.push_back(8'h12); exp_q.push_back(8'h13);
      exp_q.push_back(8'h31); exp_q.push_back(8'h32); exp_q.push_back(8'h33);
      drive();
      tick();
      check("t2_first_grant", 32'(grant), 32'd1);
      run_until(10, 40, "t2_bytes");
      check("t2_last_grant", 32'(grant), 32'd3);
      check("t2_busy_end",   32'(busy), 32'd0);
      check("t2_exp_empty",  32'(exp_q.size()), 32'd0);

      // 3: stall with A5 presented for 5 clocks
      push_src(2, 8'hA4, 1'b0); push_src(2, 8'hA5, 1'b0); push_src(2, 8'hA6, 1'b1);
      exp_q.push_back(8'hA4); exp_q.push_back(8'hA5); exp_q.push_back(8'hA6);
      drive();
      tick();
      check("t3_grant", 32'(grant), 32'd2);
      tick();
      check("t3_data_a4", 32'(data), 32'hA4);
      tick();
      check("t3_data_a5", 32'(data), 32'hA5);
      txe_n = 1'b1;
      drive();
      check("t3_tready_stall0", 32'(axis.s_axis_tready), 32'd0);
      for (int j = 0; j < 5; j++) begin
         tick();
         check("t3_hold_wr_n",   32'(wr_n), 32'd0);
         check("t3_hold_data",   32'(data), 32'hA5);
         check("t3_hold_tready", 32'(axis.s_axis_tready), 32'd0);
      end
      check("t3_cnt_stall", 32'(wr_cnt), 32'd11);
      txe_n = 1'b0;
      drive();
      check("t3_tready_resume", 32'(axis.s_axis_tready), 32'b0100);
      tick();
      tick();
      check("t3_cnt_end",   32'(wr_cnt), 32'd13);
      check("t3_exp_empty", 32'(exp_q.size()), 32'd0);
      check("t3_wr_n_end",  32'(wr_n), 32'd1);

      // 4: flush pulse 8 clocks after a single written byte, only once
      repeat (20) tick();
      siwu_cnt = 0;
      push_src(0, 8'h5A, 1'b1);
      exp_q.push_back(8'h5A);
      drive();
      tick();
      check("t4_grant", 32'(grant), 32'd0);
      tick();
      tick();
      check("t4_written", 32'(wr_cnt), 32'd14);
      repeat (30) tick();
      check("t4_siwu_count", 32'(siwu_cnt), 32'd1);
      check("t4_siwu_delay", 32'(siwu_cyc - last_wr_cyc), 32'd8);

      // 5: reset while a byte is presented
      push_src(1, 8'h51, 1'b0); push_src(1, 8'h52, 1'b0); push_src(1, 8'h53, 1'b1);
      drive();
      tick();
      check("t5_grant", 32'(grant), 32'd1);
      tick();
      check("t5_wr_n_pre", 32'(wr_n), 32'd0);
      rst_n = 1'b0;
      #1;
      check("t5_wr_n_async",  32'(wr_n), 32'd1);
      check("t5_tready_rst",  32'(axis.s_axis_tready), 32'd0);
      check("t5_grant_rst",   32'(grant), 32'd3);
      check("t5_busy_rst",    32'(busy), 32'd0);
      src_q[1].delete();
      drive();
      tick();
      push_src(0, 8'h60, 1'b1);
      push_src(2, 8'h62, 1'b1);
      exp_q.push_back(8'h60); exp_q.push_back(8'h62);
      drive();
      tick();
      rst_n = 1'b1;
      wr0 = wr_cnt;
      k = 0;
      while (state != TX_XFER && k < 10) begin
         tick();
         k++;
      end
      check("t5_xfer_after_rst", 32'(state), 32'(TX_XFER));
      check("t5_grant_after",    32'(grant), 32'd0);
      run_until(wr0 + 2, 30, "t5_bytes");
      check("t5_grant_end", 32'(grant), 32'd2);

      // 6: all sources always valid, 100 packets, random txe_n
      for (int i = 0; i < NS; i++) pkt_cnt[i] = 0;
      for (int si = 0; si < NS; si++) begin
         for (int ki = 0; ki < 25; ki++) begin
            len = 1 + (ki + si) % 3;
            for (int j = 0; j < len; j++)
               push_src(si, 8'(si * 64 + (ki * 3 + j) % 64), j == len - 1);
         end
      end
      total = 0;
      for (int p = 0; p < 100; p++) begin
         s   = (3 + p) % NS;
         kk  = p / NS;
         len = 1 + (kk + s) % 3;
         for (int j = 0; j < len; j++) exp_q.push_back(8'(s * 64 + (kk * 3 + j) % 64));
         total += len;
      end
      wr0 = wr_cnt;
      rnd_txe = 1'b1;
      drive();
      run_until(wr0 + total, 6000, "t6_bytes");
      rnd_txe = 1'b0;
      txe_n = 1'b0;
      check("t6_exp_empty", 32'(exp_q.size()), 32'd0);
      for (int i = 0; i < NS; i++) check("t6_pkt_count", 32'(pkt_cnt[i]), 32'd25);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
